// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the seven-segment capture block.
// Segment bytes are active low: bit7=a ... bit1=g, bit0=dp (dp off here).
package sevenseg_pkg;

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_OVF   = 8'hDB;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Per-digit status reported on code_out
  typedef enum logic [1:0] {
    ST_NUM   = 2'b00,
    ST_OVF   = 2'b01,
    ST_BLANK = 2'b10,
    ST_UNK   = 2'b11
  } seg_status_e;

  // Capture state machine
  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_SETTLE   = 2'b01,
    S_CAPTURED = 2'b10
  } cap_state_e;

  // True when exactly one active-low enable is asserted
  function automatic logic is_one_cold(input logic [3:0] d);
    case (d)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: is_one_cold = 1'b1;
      default:                            is_one_cold = 1'b0;
    endcase
  endfunction

  // Position of the single low enable (0 when not one-cold)
  function automatic logic [1:0] cold_index(input logic [3:0] d);
    case (d)
      4'b1110: cold_index = 2'd0;
      4'b1101: cold_index = 2'd1;
      4'b1011: cold_index = 2'd2;
      4'b0111: cold_index = 2'd3;
      default: cold_index = 2'd0;
    endcase
  endfunction

  // True when more than one enable is low at once
  function automatic logic multi_low(input logic [3:0] d);
    logic [2:0] n;
    n = {2'b00, ~d[0]} + {2'b00, ~d[1]} + {2'b00, ~d[2]} + {2'b00, ~d[3]};
    multi_low = (n > 3'd1);
  endfunction

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational lookup from segments a..g (active low) to status and BCD.
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0]  pat,
  output seg_status_e code,
  output logic [3:0]  bcd
);

  // Map each known glyph to its numeral; everything else reads as F
  always_comb begin
    code = ST_UNK;
    bcd  = 4'hF;
    case (pat)
      SEG_0[7:1]:     begin code = ST_NUM;   bcd = 4'd0; end
      SEG_1[7:1]:     begin code = ST_NUM;   bcd = 4'd1; end
      SEG_2[7:1]:     begin code = ST_NUM;   bcd = 4'd2; end
      SEG_3[7:1]:     begin code = ST_NUM;   bcd = 4'd3; end
      SEG_4[7:1]:     begin code = ST_NUM;   bcd = 4'd4; end
      SEG_5[7:1]:     begin code = ST_NUM;   bcd = 4'd5; end
      SEG_6[7:1]:     begin code = ST_NUM;   bcd = 4'd6; end
      SEG_7[7:1]:     begin code = ST_NUM;   bcd = 4'd7; end
      SEG_8[7:1]:     begin code = ST_NUM;   bcd = 4'd8; end
      SEG_9[7:1]:     begin code = ST_NUM;   bcd = 4'd9; end
      SEG_OVF[7:1]:   begin code = ST_OVF;   bcd = 4'hF; end
      SEG_BLANK[7:1]: begin code = ST_BLANK; bcd = 4'hF; end
      default:        begin code = ST_UNK;   bcd = 4'hF; end
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Reconstructs the BCD value shown on a multiplexed 4-digit common-anode
// display bus, with per-digit status, staleness timeout and frame pulse.
// Optional feature macro: SEVENSEG_CAP_DP_EN (capture decimal points).
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg,
  input  logic [3:0]  digit,
  output logic [15:0] bcd_out,
  output logic [7:0]  code_out,
  output logic [3:0]  digit_valid,
  output logic [3:0]  dp_out,
  output logic        frame_done,
  output logic        err_multi
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int AW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW-1:0] AGE_MAX = {AW{1'b1}};

  logic [7:0]    s_seg_r, p_seg_r;
  logic [3:0]    s_dig_r, p_dig_r;
  logic          seg_dp_s;
  cap_state_e    state_r, next_state_s;
  logic [CW-1:0] cnt_r, next_cnt_s;
  logic          write_s;
  logic          one_cold_s;
  logic          changed_s;
  logic [1:0]    idx_s;
  logic [3:0]    wr_mask_s;
  logic [3:0]    seen_r, seen_next_s;
  logic [AW-1:0] age_r [4];
  seg_status_e   code_s;
  logic [3:0]    bcd_s;

`ifdef SEVENSEG_CAP_DP_EN
  logic [3:0] dp_r;
  assign seg_dp_s = seg[0];
`else
  logic unused_dp_s;
  assign seg_dp_s    = 1'b1;
  assign unused_dp_s = seg[0];
`endif

  assign one_cold_s = is_one_cold(s_dig_r);
  assign changed_s  = (s_seg_r != p_seg_r) || (s_dig_r != p_dig_r);
  assign idx_s      = cold_index(s_dig_r);
  assign wr_mask_s  = write_s ? (4'b0001 << idx_s) : 4'b0000;
  assign seen_next_s = seen_r | wr_mask_s;

  sevenseg_pattern_decode u_decode (
    .pat  (s_seg_r[7:1]),
    .code (code_s),
    .bcd  (bcd_s)
  );

  // Sample the bus once and keep the previous sample for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_r <= 8'hFF;
      s_dig_r <= 4'hF;
      p_seg_r <= 8'hFF;
      p_dig_r <= 4'hF;
    end else begin
      s_seg_r <= {seg[7:1], seg_dp_s};
      s_dig_r <= digit;
      p_seg_r <= s_seg_r;
      p_dig_r <= s_dig_r;
    end
  end

  // Flag overlapping digit enables as soon as they are sampled
  always_ff @(posedge clk) begin
    if (rst) begin
      err_multi <= 1'b0;
    end else begin
      err_multi <= multi_low(digit);
    end
  end

  // Next-state logic: count unchanged cycles, write once per stable period
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    write_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        next_cnt_s = {CW{1'b0}};
        if (one_cold_s) begin
          next_state_s = S_SETTLE;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (!one_cold_s) begin
          next_state_s = S_IDLE;
          next_cnt_s   = {CW{1'b0}};
        end else if (changed_s) begin
          next_cnt_s = {CW{1'b0}};
        end else if (cnt_r == CW'(STABLE_CYCLES - 2)) begin
          write_s      = 1'b1;
          next_state_s = S_CAPTURED;
          next_cnt_s   = {CW{1'b0}};
        end else begin
          next_cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_CAPTURED: begin
        if (changed_s) begin
          next_cnt_s = {CW{1'b0}};
          if (one_cold_s) begin
            next_state_s = S_SETTLE;
          end else begin
            next_state_s = S_IDLE;
          end
        end else begin
          next_state_s = S_CAPTURED;
        end
      end
      default: begin
        next_state_s = S_IDLE;
        next_cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State and settle counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
    end
  end

  // Slot value and status registers, updated only on a capture
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_out  <= 16'hFFFF;
      code_out <= 8'hAA;
    end else if (write_s) begin
      bcd_out[{idx_s, 2'b00} +: 4] <= bcd_s;
      code_out[{idx_s, 1'b0} +: 2] <= code_s;
    end else begin
      bcd_out  <= bcd_out;
      code_out <= code_out;
    end
  end

  // Per-digit age and validity; a write on the timeout edge keeps valid set
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_valid <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        age_r[i] <= {AW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask_s[i]) begin
          age_r[i]       <= {AW{1'b0}};
          digit_valid[i] <= 1'b1;
        end else begin
          age_r[i] <= (age_r[i] == AGE_MAX) ? age_r[i] : age_r[i] + {{(AW-1){1'b0}}, 1'b1};
          if ((TIMEOUT != 0) && (((age_r[i] == AGE_MAX) ? age_r[i] : age_r[i] + {{(AW-1){1'b0}}, 1'b1}) >= AW'(TIMEOUT))) begin
            digit_valid[i] <= 1'b0;
          end else begin
            digit_valid[i] <= digit_valid[i];
          end
        end
      end
    end
  end

  // Frame tracking: pulse and restart once all four digits have been written
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_r     <= 4'b0000;
      frame_done <= 1'b0;
    end else if (seen_next_s == 4'b1111) begin
      seen_r     <= 4'b0000;
      frame_done <= 1'b1;
    end else begin
      seen_r     <= seen_next_s;
      frame_done <= 1'b0;
    end
  end

`ifdef SEVENSEG_CAP_DP_EN
  // Decimal point captured alongside the digit value
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_r <= 4'b0000;
    end else if (write_s) begin
      dp_r[idx_s] <= ~s_seg_r[0];
    end else begin
      dp_r <= dp_r;
    end
  end
  assign dp_out = dp_r;
`else
  assign dp_out = 4'b0000;
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
// Randomized bench for sevenseg_capture against a run-length reference model.
module tb_sevenseg_capture;

  localparam int SC = 4;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_d;
  logic [7:0]  seg_d;
  logic [3:0]  dig_d;
  logic [15:0] bcd_out;
  logic [7:0]  code_out;
  logic [3:0]  digit_valid;
  logic [3:0]  dp_out;
  logic        frame_done;
  logic        err_multi;

  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt = 0;

  // Reference state: last sampled bus value and how many samples it has lasted
  logic [7:0]  m_seg;
  logic [3:0]  m_dig;
  int          m_run;
  int          m_since [4];
  logic [3:0]  m_seen;
  logic [15:0] m_bcd;
  logic [7:0]  m_code;
  logic [3:0]  m_valid;
  logic [3:0]  m_dp;
  logic        m_fd;
  logic        m_err;

  sevenseg_capture #(.STABLE_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst_d), .seg(seg_d), .digit(dig_d),
    .bcd_out(bcd_out), .code_out(code_out), .digit_valid(digit_valid),
    .dp_out(dp_out), .frame_done(frame_done), .err_multi(err_multi)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [7:0] s, output logic [1:0] c, output logic [3:0] b);
    logic [79:0] nums;
    logic [7:0]  t;
    nums = {8'h09, 8'h01, 8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03};
    t = s | 8'h01;
    c = 2'b11;
    b = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (t == nums[k*8 +: 8]) begin
        c = 2'b00;
        b = 4'(k);
      end
    end
    if (t == 8'hDB) c = 2'b01;
    if (t == 8'hFF) c = 2'b10;
  endfunction

  function automatic int zeros(input logic [3:0] d);
    int n = 0;
    for (int k = 0; k < 4; k++) if (!d[k]) n++;
    return n;
  endfunction

  // Advance the reference by one rising edge with the inputs present at it
  task automatic model_edge();
    logic       wr;
    int         idx;
    logic [1:0] c;
    logic [3:0] b;
    logic [7:0] ns;
    if (rst_d) begin
      m_seg = 8'hFF; m_dig = 4'hF; m_run = 1; m_seen = 4'b0000;
      m_bcd = 16'hFFFF; m_code = 8'hAA; m_valid = 4'b0000; m_dp = 4'b0000;
      m_fd = 1'b0; m_err = 1'b0;
      for (int k = 0; k < 4; k++) m_since[k] = 0;
    end else begin
      wr  = (zeros(m_dig) == 1) && (m_run == SC);
      idx = 0;
      for (int k = 0; k < 4; k++) if (!m_dig[k]) idx = k;
      for (int k = 0; k < 4; k++) begin
        if (wr && k == idx) begin
          m_since[k] = 0;
          m_valid[k] = 1'b1;
        end else begin
          if (m_since[k] < 1000) m_since[k]++;
          if (m_since[k] >= TO) m_valid[k] = 1'b0;
        end
      end
      if (wr) begin
        ref_decode(m_seg, c, b);
        m_bcd[idx*4 +: 4]  = b;
        m_code[idx*2 +: 2] = c;
`ifdef SEVENSEG_CAP_DP_EN
        m_dp[idx] = ~m_seg[0];
`endif
        m_seen[idx] = 1'b1;
      end
      if (m_seen == 4'b1111) begin
        m_fd = 1'b1; m_seen = 4'b0000;
      end else begin
        m_fd = 1'b0;
      end
      m_err = (zeros(dig_d) > 1);
`ifdef SEVENSEG_CAP_DP_EN
      ns = seg_d;
`else
      ns = seg_d | 8'h01;
`endif
      if (ns == m_seg && dig_d == m_dig) begin
        if (m_run <= SC) m_run++;
      end else begin
        m_run = 1;
      end
      m_seg = ns;
      m_dig = dig_d;
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (frame_done === 1'b1) fd_cnt++;
    check_eq("bcd_out", 32'(bcd_out), 32'(m_bcd));
    check_eq("code_out", 32'(code_out), 32'(m_code));
    check_eq("digit_valid", 32'(digit_valid), 32'(m_valid));
    check_eq("dp_out", 32'(dp_out), 32'(m_dp));
    check_eq("frame_done", 32'(frame_done), 32'(m_fd));
    check_eq("err_multi", 32'(err_multi), 32'(m_err));
  endtask

  task automatic hold(input logic [7:0] s, input logic [3:0] d, input int n);
    seg_d = s;
    dig_d = d;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst_d = 1'b1;
    step();
    rst_d = 1'b0;
  endtask

  initial begin
    int first;
    logic [7:0] pats [13];
    pats = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09, 8'hDB, 8'hFF, 8'h55};
    seg_d = 8'hFF; dig_d = 4'hF; rst_d = 1'b1;
    @(negedge clk);
    step();
    step();
    rst_d = 1'b0;
    check_eq("reset_bcd", 32'(bcd_out), 32'h0000FFFF);
    check_eq("reset_code", 32'(code_out), 32'h000000AA);

    // Exact capture latency on digit 0
    seg_d = 8'h0D; dig_d = 4'b1110; first = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (first == 0 && digit_valid[0] === 1'b1) first = k;
    end
    check_eq("latency", 32'(first), 32'(SC + 1));
    check_eq("latency_bcd", 32'(bcd_out[3:0]), 32'h3);

    // Full scan 1,2,3,4 produces one frame pulse
    do_reset();
    fd_cnt = 0;
    hold(8'h9F, 4'b1110, 6);
    hold(8'h25, 4'b1101, 6);
    hold(8'h0D, 4'b1011, 6);
    hold(8'h99, 4'b0111, 6);
    hold(8'hFF, 4'b1111, 2);
    check_eq("scan_bcd", 32'(bcd_out), 32'h00004321);
    check_eq("scan_frames", 32'(fd_cnt), 32'd1);

    // Glitching pattern never settles, then a held 8 is captured
    do_reset();
    for (int r = 0; r < 6; r++) hold((r % 2 == 1) ? 8'h25 : 8'h99, 4'b1101, SC - 1);
    check_eq("glitch_nowrite", 32'(digit_valid), 32'd0);
    hold(8'h01, 4'b1101, 8);
    check_eq("glitch_then_8", 32'(bcd_out[7:4]), 32'h8);

    // Overflow, blank and unknown glyphs
    hold(8'hDB, 4'b1110, 6);
    hold(8'hFF, 4'b1101, 6);
    hold(8'h55, 4'b1011, 6);
    check_eq("status_codes", 32'(code_out[5:0]), 32'b111001);
    check_eq("status_bcd", 32'(bcd_out[11:0]), 32'hFFF);

    // Two enables low: error after one cycle, nothing captured
    hold(8'h03, 4'b1100, 1);
    check_eq("multi_err", 32'(err_multi), 32'd1);
    hold(8'h03, 4'b1100, 6);
    check_eq("multi_nocap", 32'(bcd_out[3:0]), 32'hF);

    // No refresh: every digit goes stale
    hold(8'hFF, 4'b1111, TO + 10);
    check_eq("timeout_valid", 32'(digit_valid), 32'd0);

    // Reset mid-settle and mid-frame
    hold(8'h25, 4'b0111, 2);
    do_reset();
    check_eq("rst_settle_code", 32'(code_out), 32'h000000AA);
    hold(8'h9F, 4'b1110, 6);
    hold(8'h25, 4'b1101, 6);
    hold(8'h0D, 4'b1011, 6);
    do_reset();
    fd_cnt = 0;
    hold(8'h99, 4'b0111, 8);
    check_eq("rst_midframe", 32'(fd_cnt), 32'd0);

    // Randomized bus traffic
    for (int it = 0; it < 400; it++) begin
      logic [3:0] d;
      logic [7:0] s;
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 5) d = ~(4'b0001 << $urandom_range(0, 3));
      else if (r <= 7) d = 4'hF;
      else d = 4'($urandom);
      if ($urandom_range(0, 5) == 0) s = 8'($urandom);
      else s = pats[$urandom_range(0, 12)] & {7'h7F, 1'($urandom)};
      if ($urandom_range(0, 39) == 0) do_reset();
      hold(s, d, int'($urandom_range(1, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
# sevenseg_capture

Receive-side counterpart of the team's BCD-to-seven-segment encoder. It observes a multiplexed 4-digit common-anode display bus (active-low segments, active-low digit enables) and reconstructs the BCD value shown on each digit, with per-digit status, staleness timeout and frame completion. It is used for display loop-back self-test on the board and as a checker in system benches.

## Interface
- STABLE_CYCLES, default 4: cycles a single-digit pattern must stay unchanged before capture; legal range is 2 or more.
- TIMEOUT, default 65535: cycles without refresh before a digit's valid flag clears; 0 disables the timeout.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- seg  in  8  segment bus, active low; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
- digit  in  4  digit enables, active low; bit0 = rightmost digit.
- bcd_out  out  16  captured BCD value; digit i occupies bits [4i+3:4i].
- code_out  out  8  per-digit status, 2 bits per digit: 00 numeral, 01 overflow mark, 10 blank, 11 unknown.
- digit_valid  out  4  digit captured and not timed out.
- dp_out  out  4  captured decimal-point state, 1 = lit.
- frame_done  out  1  one-cycle pulse when all four digits have been captured since the previous pulse.
- err_multi  out  1  registered flag, high while more than one digit enable is active.

## Operation
- Inputs are registered once into s_seg and s_dig. All logic uses the registered copies.
- Decode uses s_seg[7:1] only:
  - 0x03>>1..0x09>>1 patterns: 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100. These give code 00 and the matching BCD value.
  - 1101101 gives overflow mark: code 01, BCD 4'hF.
  - 1111111 gives blank: code 10, BCD 4'hF.
  - Any other pattern gives unknown: code 11, BCD 4'hF.
- FSM states:
  - IDLE: s_dig is not one-cold. Go to SETTLE when s_dig becomes one-cold.
  - SETTLE: count cnt on each cycle where s_seg and s_dig are unchanged from the previous cycle. Any change restarts cnt at 0. If s_dig is no longer one-cold, go to IDLE. When cnt reaches STABLE_CYCLES-1, write the slot and go to CAPTURED.
  - CAPTURED: hold. Any change in s_seg or s_dig goes to SETTLE, or to IDLE if s_dig is not one-cold. The slot is written only once per stable period.
- A slot write updates bcd_out, code_out and dp_out for the selected digit. It also sets digit_valid[i], clears age[i] and sets seen[i].
- Every cycle, each age[i] increments and saturates. When TIMEOUT is nonzero and age[i] reaches TIMEOUT, digit_valid[i] clears and the other slot fields hold their values.
- frame_done pulses when seen becomes 4'b1111. seen clears on the same edge. A write on that same edge counts toward the current frame.
- err_multi = more than one bit of s_dig is low. When digit is all ones, the block sits in IDLE without error.

## Timing
- Reset values: bcd_out=16'hFFFF, code_out=8'hAA (all blank), digit_valid=0, dp_out=0, frame_done=0, err_multi=0. Reset also sets FSM=IDLE, cnt=0, age=0 and seen=0.
- A value first sampled into s_* at edge N that stays unchanged through edge N+STABLE_CYCLES-1 appears on the outputs after edge N+STABLE_CYCLES.
- frame_done asserts in the same cycle as the outputs of the completing write.
- err_multi lags the inputs by 1 cycle.
- Reset takes priority over all events. A reset asserted mid-SETTLE discards the pending capture.
- When a timeout and a write hit the same digit on the same edge, the write wins: valid stays 1 and age goes to 0.

## Configuration
- SEVENSEG_CAP_DP_EN defined: dp_out[i] captures ~s_seg[0] on each write to slot i.
- SEVENSEG_CAP_DP_EN undefined: dp_out is tied to 0 and seg[0] is ignored entirely.
- Decode is unaffected in both cases.

## Structure
- sevenseg_pkg holds:
  - the segment pattern constants SEG_0..SEG_9, SEG_OVF=8'hDB and SEG_BLANK=8'hFF;
  - the 2-bit status enum;
  - the FSM state enum.
- One sub-module, sevenseg_pattern_decode, is the combinational lookup from seg[7:1] to {code, bcd}. The FSM, counters and slot registers stay in sevenseg_capture.

## Test plan
- Digit enable 4'b1110 with seg 8'h0D, held 10 cycles → bcd_out[3:0]=3, code 00, digit_valid=4'b0001, exactly at the defined latency.
- Scan digits 0..3 showing 1,2,3,4 (8'h9F, 8'h25, 8'h0D, 8'h99) → bcd_out=16'h4321, frame_done pulses once after digit 3, seen clears.
- Glitch: pattern changes every STABLE_CYCLES-1 cycles → no write occurs. Then hold 8'h01 → value 8 is captured once.
- seg 8'hDB, 8'hFF, 8'h55 on digits 0, 1, 2 → codes 01, 10, 11; BCD nibbles F.
- digit 4'b1100 → err_multi=1 after 1 cycle and no capture. With TIMEOUT=20 and no refresh → digit_valid clears at age 20.
- Reset asserted mid-SETTLE and mid-frame → all outputs return to reset values, and the next frame_done requires all four digits again.
